uart_tx_arbiter: RTL and testbench
==================================

# uart_tx_arbiter

Round-robin arbiter and sequencer that shares one UART transmitter among `NUM_REQ` byte producers. It accepts a byte from one requester at a time, issues the transmitter's one-cycle send strobe, and holds the byte stable until the transmitter reports completion. It sits between on-chip byte sources and the transmitter's `send`/`data_in`/`active_flag`/`done_flag` port. It also detects a transmitter that never starts a frame.

## Interface

Parameters:
- `NUM_REQ`, 4: number of requesters, 2..8.
- `START_TIMEOUT`, 1023: maximum cycles in WAIT_ACTIVE before abort, at least 1.

Ports (one clock; reset is synchronous and active-high):
- `clock` in 1: system clock, shared with the transmitter.
- `reset` in 1: synchronous, active-high.
- `enable` in 1: when low, no new grant is issued. An in-flight byte still completes.
- `req_valid` in NUM_REQ: per-requester byte available. Held until accepted.
- `req_data` in NUM_REQ*8: requester i occupies bits [8i+7:8i].
- `req_ready` out NUM_REQ: one-hot, one-cycle accept pulse.
- `tx_send` out 1: one-cycle send strobe to the transmitter.
- `tx_data` out 8: byte to the transmitter. Stable from SEND until return to IDLE.
- `tx_active` in 1: transmitter active flag.
- `tx_done` in 1: transmitter done pulse.
- `busy` out 1: high in every state except IDLE.
- `grant_id` out clog2(NUM_REQ): index of the current or last granted requester.
- `timeout_err` out 1: one-cycle pulse when the start timeout fires.

## Operation

States: IDLE, SEND, WAIT_ACTIVE, WAIT_DONE.

IDLE:
- Transition requires `enable` = 1 and any `req_valid` bit set.
- Winner is the first set bit searching from `ptr`+1 upward, wrapping modulo NUM_REQ.
- On the transition edge: capture the winner's byte into `tx_data`, set `grant_id` to the winner, set `ptr` to the winner, go to SEND.

SEND:
- Exactly one cycle.
- `tx_send` = 1 and `req_ready[grant_id]` = 1. Go to WAIT_ACTIVE.

WAIT_ACTIVE:
- Counter increments each cycle.
- If `tx_done` = 1: go to IDLE. A done pulse takes precedence over `tx_active`.
- Else if `tx_active` = 1: go to WAIT_DONE.
- Else if the counter reaches START_TIMEOUT: pulse `timeout_err` and go to IDLE. The byte is dropped and not retried.

WAIT_DONE:
- Wait for `tx_done` = 1, then go to IDLE. No timeout in this state.

Other rules:
- Round-robin pointer `ptr` resets to NUM_REQ-1, so requester 0 has first priority after reset.
- `req_valid` bits of non-granted requesters are ignored while busy.
- The requester must treat the `req_ready` cycle as consumption of the byte.
- `enable` is sampled only in IDLE.

## Timing

- Reset values:
  - state IDLE; `ptr` = NUM_REQ-1; counter 0.
  - `tx_send`, `req_ready`, `busy`, `timeout_err`: 0.
  - `tx_data` = 0x00; `grant_id` = 0.
- Latency: `req_valid` high in IDLE at cycle t, so `tx_send` and `req_ready` are high in cycle t+1, and `busy` is high from t+1.
- Registered outputs only. No combinational path from any input to any output.
- Back-to-back: `tx_done` at cycle d gives IDLE at d+1. The next `tx_send` comes at d+2 at the earliest, so there is a minimum one-cycle IDLE gap.
- Timeout: with `tx_active` held low, `timeout_err` pulses START_TIMEOUT cycles after the SEND cycle, and the block is in IDLE the following cycle.
- Reset asserted mid-operation returns to reset values on the next edge. No partial `tx_send` or `req_ready` pulse is emitted.

## Structure

- Shared package `uart_pkg`:
  - state encoding typedef `tx_arb_state_t`.
  - constant `UART_DATA_W` = 8.
- One sub-module `rr_pick`: combinational round-robin selector.
  - inputs: request vector, `ptr`.
  - outputs: one-hot grant, index, any-valid.
- The state machine, timeout counter and data register live in `uart_tx_arbiter`.
- `uart_tx_arbiter` is instantiated next to `transmitter_d` in the top level.

## Test plan

1. Single requester, byte 0xA5: `req_valid[2]` high with 0xA5. `tx_send` and `req_ready[2]` fire one cycle later, with `tx_data` = 0xA5 and `grant_id` = 2. After the model's `tx_done`, `busy` falls.
2. Fairness: all four `req_valid` held high with bytes 0x10/0x11/0x12/0x13. Sends occur in order 0,1,2,3,0 with matching bytes. Each requester gets exactly one `req_ready` per round.
3. Wrap-around: after granting requester 3, only requesters 1 and 3 are valid. Grant goes to 1, then to 3.
4. Timeout, START_TIMEOUT = 16: the transmitter model never raises active. `timeout_err` pulses 16 cycles after SEND, the block returns to IDLE, and the next requester is served.
5. Enable and done precedence:
   - `enable` = 0 while `req_valid[0]` is high: no `tx_send`.
   - Raise `enable`: `tx_send` follows one cycle later.
   - In a separate run, a `tx_done` in WAIT_ACTIVE with `tx_active` low returns the block to IDLE.
6. Reset mid-frame: assert `reset` during WAIT_DONE. All outputs are at reset values one edge later. Requester 0 wins first afterwards, even with all requesters valid.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit arbiter: byte width,
// arbiter state encoding and an index-width helper.
package uart_pkg;

   localparam int UART_DATA_W = 8;

   typedef enum logic [1:0] {
      ST_IDLE        = 2'd0,
      ST_SEND        = 2'd1,
      ST_WAIT_ACTIVE = 2'd2,
      ST_WAIT_DONE   = 2'd3
   } tx_arb_state_t;

   // Width of an index into n requesters (never narrower than one bit).
   function automatic int id_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Handshake bundle between byte producers, the arbiter and the UART
// transmitter. The arbiter takes the master view; producers and the
// transmitter together form the slave view.
interface uart_tx_arbiter_if #(
   parameter int NUM_REQ = 4
);
   localparam int ID_W = uart_pkg::id_width(NUM_REQ);

   logic                                      enable;
   logic [NUM_REQ-1:0]                        req_valid;
   logic [NUM_REQ*uart_pkg::UART_DATA_W-1:0]  req_data;
   logic [NUM_REQ-1:0]                        req_ready;
   logic                                      tx_send;
   logic [uart_pkg::UART_DATA_W-1:0]          tx_data;
   logic                                      tx_active;
   logic                                      tx_done;
   logic                                      busy;
   logic [ID_W-1:0]                           grant_id;
   logic                                      timeout_err;

   modport master (
      input  enable, req_valid, req_data, tx_active, tx_done,
      output req_ready, tx_send, tx_data, busy, grant_id, timeout_err
   );

   modport slave (
      output enable, req_valid, req_data, tx_active, tx_done,
      input  req_ready, tx_send, tx_data, busy, grant_id, timeout_err
   );

endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin selector: returns the first requesting
// index found searching upward from ptr+1, wrapping modulo NUM_REQ.
module rr_pick
   import uart_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = id_width(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req_vec,
   input  logic [ID_W-1:0]    ptr,
   output logic [NUM_REQ-1:0] grant,
   output logic [ID_W-1:0]    grant_idx,
   output logic               any_valid
);

   // cand_idx[k] is the requester examined at search position k.
   logic [ID_W-1:0] cand_idx [NUM_REQ];

   genvar gi;
   generate
      for (gi = 0; gi < NUM_REQ; gi++) begin : g_cand
         logic [ID_W:0] sum;
         assign sum          = {1'b0, ptr} + (ID_W+1)'(gi + 1);
         assign cand_idx[gi] = (sum >= (ID_W+1)'(NUM_REQ))
                               ? ID_W'(sum - (ID_W+1)'(NUM_REQ))
                               : sum[ID_W-1:0];
      end
   endgenerate

   // Priority scan over the rotated order; the first hit wins.
   always_comb begin
      grant     = '0;
      grant_idx = '0;
      any_valid = 1'b0;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (!any_valid && req_vec[cand_idx[k]]) begin
            any_valid = 1'b1;
            grant_idx = cand_idx[k];
         end
      end
      if (any_valid) begin
         grant[grant_idx] = 1'b1;
      end
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter among NUM_REQ byte producers. Grants one
// byte at a time round-robin, strobes send for one cycle, holds the byte
// until the transmitter reports done, and aborts when the transmitter
// never goes active within START_TIMEOUT cycles.
module uart_tx_arbiter
   import uart_pkg::*;
#(
   parameter int NUM_REQ       = 4,
   parameter int START_TIMEOUT = 1023
) (
   input  logic              clock,
   input  logic              reset,
   uart_tx_arbiter_if.master bus
);

   localparam int ID_W  = id_width(NUM_REQ);
   localparam int CNT_W = $clog2(START_TIMEOUT + 1);

   localparam logic [ID_W-1:0]  PTR_INIT = ID_W'(NUM_REQ - 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(START_TIMEOUT - 1);
   // With a one-cycle budget the pulse has to be scheduled on the SEND edge.
   localparam bit TIMEOUT_AT_SEND = (START_TIMEOUT == 1);

   tx_arb_state_t          state_reg;
   logic [ID_W-1:0]        ptr_reg;
   logic [ID_W-1:0]        grant_id_reg;
   logic [CNT_W-1:0]       cnt_reg;
   logic [UART_DATA_W-1:0] tx_data_reg;
   logic [NUM_REQ-1:0]     req_ready_reg;
   logic                   tx_send_reg;
   logic                   busy_reg;
   logic                   timeout_err_reg;

   logic [NUM_REQ-1:0]     pick_grant;
   logic [ID_W-1:0]        pick_idx;
   logic                   pick_any;

   logic [UART_DATA_W-1:0] req_bytes [NUM_REQ];

   genvar gi;
   generate
      for (gi = 0; gi < NUM_REQ; gi++) begin : g_bytes
         assign req_bytes[gi] = bus.req_data[gi*UART_DATA_W +: UART_DATA_W];
      end
   endgenerate

   rr_pick #(
      .NUM_REQ (NUM_REQ),
      .ID_W    (ID_W)
   ) u_pick (
      .req_vec   (bus.req_valid),
      .ptr       (ptr_reg),
      .grant     (pick_grant),
      .grant_idx (pick_idx),
      .any_valid (pick_any)
   );

   // Sequencer: grant, strobe, wait for start, wait for done; all outputs registered.
   // cnt_reg holds the number of cycles elapsed since the SEND cycle, so the
   // timeout pulse is high exactly in the cycle where that count equals
   // START_TIMEOUT, and the block is back in IDLE on the cycle after.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_reg       <= ST_IDLE;
         ptr_reg         <= PTR_INIT;
         grant_id_reg    <= '0;
         cnt_reg         <= '0;
         tx_data_reg     <= '0;
         req_ready_reg   <= '0;
         tx_send_reg     <= 1'b0;
         busy_reg        <= 1'b0;
         timeout_err_reg <= 1'b0;
      end else begin
         tx_send_reg     <= 1'b0;
         req_ready_reg   <= '0;
         timeout_err_reg <= 1'b0;
         case (state_reg)
            ST_IDLE: begin
               cnt_reg <= '0;
               if (bus.enable && pick_any) begin
                  state_reg     <= ST_SEND;
                  tx_send_reg   <= 1'b1;
                  req_ready_reg <= pick_grant;
                  tx_data_reg   <= req_bytes[pick_idx];
                  grant_id_reg  <= pick_idx;
                  ptr_reg       <= pick_idx;
                  busy_reg      <= 1'b1;
               end
            end
            ST_SEND: begin
               state_reg       <= ST_WAIT_ACTIVE;
               cnt_reg         <= CNT_W'(1);
               timeout_err_reg <= TIMEOUT_AT_SEND;
            end
            ST_WAIT_ACTIVE: begin
               cnt_reg <= cnt_reg + CNT_W'(1);
               if (timeout_err_reg) begin
                  // Timed out: the byte is dropped, not retried.
                  state_reg <= ST_IDLE;
                  busy_reg  <= 1'b0;
               end else if (bus.tx_done) begin
                  state_reg <= ST_IDLE;
                  busy_reg  <= 1'b0;
               end else if (bus.tx_active) begin
                  state_reg <= ST_WAIT_DONE;
               end else if (cnt_reg == CNT_LAST) begin
                  timeout_err_reg <= 1'b1;
               end
            end
            ST_WAIT_DONE: begin
               if (bus.tx_done) begin
                  state_reg <= ST_IDLE;
                  busy_reg  <= 1'b0;
               end
            end
            default: begin
               state_reg <= ST_IDLE;
               busy_reg  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.req_ready   = req_ready_reg;
   assign bus.tx_send     = tx_send_reg;
   assign bus.tx_data     = tx_data_reg;
   assign bus.busy        = busy_reg;
   assign bus.grant_id    = grant_id_reg;
   assign bus.timeout_err = timeout_err_reg;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: directed requester traffic, a
// small transmitter model, and a monitor that pops expected sends.
module tb_uart_tx_arbiter;
   import uart_pkg::*;

   localparam int NUM_REQ       = 4;
   localparam int START_TIMEOUT = 16;

   typedef struct packed {
      logic [1:0] id;
      logic [7:0] data;
   } exp_t;

   logic clock = 1'b0;
   logic reset;
   int   checks = 0;
   int   errors = 0;
   int   model_mode = 0;   // 0 normal, 1 never active, 2 done without active
   exp_t exp_q [$];

   logic [7:0] rbuf [NUM_REQ][8];
   int         rcnt [NUM_REQ];
   int         rhead [NUM_REQ];

   always #5 clock = ~clock;

   uart_tx_arbiter_if #(.NUM_REQ(NUM_REQ)) bus ();

   uart_tx_arbiter #(
      .NUM_REQ       (NUM_REQ),
      .START_TIMEOUT (START_TIMEOUT)
   ) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   task automatic drive_reqs();
      for (int i = 0; i < NUM_REQ; i++) begin
         if (rhead[i] < rcnt[i]) begin
            bus.req_valid[i]         = 1'b1;
            bus.req_data[i*8 +: 8]   = rbuf[i][rhead[i]];
         end else begin
            bus.req_valid[i]         = 1'b0;
            bus.req_data[i*8 +: 8]   = 8'h00;
         end
      end
   endtask

   // One cycle: sample at negedge, consume accepted bytes, re-drive requesters.
   task automatic step();
      @(negedge clock);
      for (int i = 0; i < NUM_REQ; i++) begin
         if (bus.req_ready[i]) rhead[i]++;
      end
      drive_reqs();
   endtask

   task automatic load(input int i, input logic [7:0] b);
      rbuf[i][rcnt[i]] = b;
      rcnt[i]++;
      drive_reqs();
   endtask

   task automatic expect_send(input int id, input logic [7:0] b);
      exp_t e;
      e.id   = 2'(id);
      e.data = b;
      exp_q.push_back(e);
   endtask

   task automatic wait_send(input int bound, output int n);
      n = 0;
      do begin
         step();
         n++;
      end while (!bus.tx_send && n < bound);
      check("send_seen", {31'd0, bus.tx_send}, 1);
   endtask

   task automatic wait_drain(input int bound);
      int n;
      n = 0;
      while ((exp_q.size() != 0 || bus.busy) && n < bound) begin
         step();
         n++;
      end
      check("drain", {31'd0, (exp_q.size() == 0 && !bus.busy)}, 1);
   endtask

   task automatic do_reset();
      reset      = 1'b1;
      bus.enable = 1'b1;
      for (int i = 0; i < NUM_REQ; i++) begin
         rcnt[i]  = 0;
         rhead[i] = 0;
      end
      drive_reqs();
      step();
      step();
      reset = 1'b0;
   endtask

   // Transmitter model reacting to the send strobe.
   initial begin
      bus.tx_active = 1'b0;
      bus.tx_done   = 1'b0;
      forever begin
         @(negedge clock);
         if (bus.tx_send && !reset) begin
            case (model_mode)
               0: begin
                  @(negedge clock);
                  bus.tx_active = 1'b1;
                  repeat (3) @(negedge clock);
                  bus.tx_active = 1'b0;
                  bus.tx_done   = 1'b1;
                  @(negedge clock);
                  bus.tx_done   = 1'b0;
               end
               2: begin
                  @(negedge clock);
                  bus.tx_done = 1'b1;
                  @(negedge clock);
                  bus.tx_done = 1'b0;
               end
               default: ;
            endcase
         end
      end
   end

   // Monitor: pops the scoreboard on every send and checks held data.
   initial begin
      exp_t       e;
      logic [7:0] last_data;
      last_data = 8'h00;
      forever begin
         @(negedge clock);
         if (bus.tx_send) begin
            if (exp_q.size() == 0) begin
               check("unexpected_send", 32'(bus.tx_data), 32'hFFFF_FFFF);
            end else begin
               e = exp_q.pop_front();
               check("send_id", 32'(bus.grant_id), 32'(e.id));
               check("send_data", 32'(bus.tx_data), 32'(e.data));
               check("send_ready", 32'(bus.req_ready), 32'(1) << e.id);
               $display("send id=%0d data=%02h", bus.grant_id, bus.tx_data);
            end
            last_data = bus.tx_data;
         end else begin
            check("ready_quiet", 32'(bus.req_ready), 0);
            if (bus.busy) check("data_stable", 32'(bus.tx_data), 32'(last_data));
         end
      end
   end

   // Watchdog.
   initial begin
      #100000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      bus.enable    = 1'b1;
      bus.req_valid = '0;
      bus.req_data  = '0;
      reset         = 1'b1;

      // Reset values
      do_reset();
      check("rst_busy",     32'(bus.busy), 0);
      check("rst_send",     32'(bus.tx_send), 0);
      check("rst_ready",    32'(bus.req_ready), 0);
      check("rst_timeout",  32'(bus.timeout_err), 0);
      check("rst_data",     32'(bus.tx_data), 0);
      check("rst_grant",    32'(bus.grant_id), 0);

      // 1: single requester, byte A5
      load(2, 8'hA5);
      expect_send(2, 8'hA5);
      step();
      check("t1_latency_send",  32'(bus.tx_send), 1);
      check("t1_latency_ready", 32'(bus.req_ready), 32'h4);
      check("t1_busy",          32'(bus.busy), 1);
      repeat (4) step();
      check("t1_busy_before_done", 32'(bus.busy), 1);
      step();
      check("t1_busy_fall", 32'(bus.busy), 0);

      // 2: fairness 0,1,2,3,0 with back-to-back spacing
      do_reset();
      load(0, 8'h10); load(0, 8'h20);
      load(1, 8'h11); load(2, 8'h12); load(3, 8'h13);
      expect_send(0, 8'h10); expect_send(1, 8'h11); expect_send(2, 8'h12);
      expect_send(3, 8'h13); expect_send(0, 8'h20);
      wait_send(10, n);
      for (int k = 0; k < 4; k++) begin
         wait_send(20, n);
         check("t2_gap", 32'(n), 6);
      end
      wait_drain(50);
      check("t2_rounds_r0", 32'(rhead[0]), 2);
      check("t2_rounds_r1", 32'(rhead[1]), 1);
      check("t2_rounds_r2", 32'(rhead[2]), 1);
      check("t2_rounds_r3", 32'(rhead[3]), 1);

      // 3: wrap-around after requester 3
      load(3, 8'h33);
      expect_send(3, 8'h33);
      wait_drain(50);
      load(1, 8'h41); load(3, 8'h43);
      expect_send(1, 8'h41); expect_send(3, 8'h43);
      wait_drain(50);

      // 4: start timeout, next requester still served
      model_mode = 1;
      load(0, 8'hE0); load(1, 8'hE1);
      expect_send(0, 8'hE0); expect_send(1, 8'hE1);
      wait_send(10, n);
      n = 0;
      do begin
         step();
         n++;
      end while (!bus.timeout_err && n < 30);
      check("t4_timeout_cycles", 32'(n), START_TIMEOUT);
      check("t4_busy_at_pulse", 32'(bus.busy), 1);
      model_mode = 0;
      step();
      check("t4_idle_after", 32'(bus.busy), 0);
      check("t4_pulse_width", 32'(bus.timeout_err), 0);
      wait_drain(50);

      // 5a: enable gating
      bus.enable = 1'b0;
      load(0, 8'h5A);
      for (int k = 0; k < 5; k++) begin
         step();
         check("t5_disabled_send", 32'(bus.tx_send), 0);
      end
      expect_send(0, 8'h5A);
      bus.enable = 1'b1;
      step();
      check("t5_enable_latency", 32'(bus.tx_send), 1);
      wait_drain(50);

      // 5b: done while waiting for active
      model_mode = 2;
      load(2, 8'hD2);
      expect_send(2, 8'hD2);
      wait_send(10, n);
      step();
      check("t5_busy_wait_active", 32'(bus.busy), 1);
      step();
      check("t5_done_precedence", 32'(bus.busy), 0);
      check("t5_no_timeout", 32'(bus.timeout_err), 0);
      model_mode = 0;

      // 6: reset during WAIT_DONE
      load(1, 8'h61);
      expect_send(1, 8'h61);
      wait_send(10, n);
      step();
      step();
      check("t6_busy_wait_done", 32'(bus.busy), 1);
      reset = 1'b1;
      step();
      check("t6_rst_busy",  32'(bus.busy), 0);
      check("t6_rst_data",  32'(bus.tx_data), 0);
      check("t6_rst_grant", 32'(bus.grant_id), 0);
      check("t6_rst_send",  32'(bus.tx_send), 0);
      load(0, 8'h70); load(1, 8'h71); load(2, 8'h72); load(3, 8'h73);
      expect_send(0, 8'h70); expect_send(1, 8'h71);
      expect_send(2, 8'h72); expect_send(3, 8'h73);
      for (int k = 0; k < 3; k++) begin
         step();
         check("t6_held_send", 32'(bus.tx_send), 0);
      end
      reset = 1'b0;
      step();
      check("t6_first_send", 32'(bus.tx_send), 1);
      check("t6_first_grant", 32'(bus.grant_id), 0);
      wait_drain(100);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
